// File: rtl/demux_buf.sv
// Registered 1-to-2 demultiplexer with an independent FIFO per output.
// Optional same-cycle bypass into an empty FIFO: define DEMUX_BUF_BYPASS_EN.
module demux_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out2_valid,
   input  logic             out2_ready,
   output logic [WIDTH-1:0] out2_data,
   output logic [CW-1:0]    out1_count,
   output logic [CW-1:0]    out2_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem   [2][DEPTH];
   logic [PW-1:0]    wrptr [2];
   logic [PW-1:0]    rdptr [2];
   logic [CW-1:0]    count [2];

   logic [1:0]    push;
   logic [1:0]    pop;
   logic [1:0]    byp;
   logic [1:0]    out_rdy;
   logic [1:0]    sel_oh;
   logic [CW-1:0] sel_count;

   assign out_rdy   = {out2_ready, out1_ready};
   assign sel_oh    = {in_sel, ~in_sel};
   assign sel_count = in_sel ? count[1] : count[0];

   // Depends only on registered occupancy, never on the consumer readies.
   assign in_ready  = rst_n & (sel_count < FULL);

   always_comb begin
      push = '0;
      pop  = '0;
      byp  = '0;
      for (int c = 0; c < 2; c++) begin
`ifdef DEMUX_BUF_BYPASS_EN
         byp[c]  = (count[c] == '0) & in_valid & sel_oh[c] & out_rdy[c];
`endif
         push[c] = in_valid & in_ready & sel_oh[c] & ~byp[c];
         pop[c]  = (count[c] != '0) & out_rdy[c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem[c][i] <= '0;
            end
            wrptr[c] <= '0;
            rdptr[c] <= '0;
            count[c] <= '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
               mem[c][wrptr[c]] <= in_data;
               wrptr[c]         <= wrptr[c] + PW'(1);
            end
            if (pop[c]) begin
               rdptr[c] <= rdptr[c] + PW'(1);
            end
            case ({push[c], pop[c]})
               2'b10:   count[c] <= count[c] + CW'(1);
               2'b01:   count[c] <= count[c] - CW'(1);
               default: count[c] <= count[c];
            endcase
         end
      end
   end

`ifdef DEMUX_BUF_BYPASS_EN
   assign out1_valid = (count[0] != '0) | byp[0];
   assign out2_valid = (count[1] != '0) | byp[1];
   assign out1_data  = byp[0] ? in_data : mem[0][rdptr[0]];
   assign out2_data  = byp[1] ? in_data : mem[1][rdptr[1]];
`else
   assign out1_valid = (count[0] != '0);
   assign out2_valid = (count[1] != '0);
   assign out1_data  = mem[0][rdptr[0]];
   assign out2_data  = mem[1][rdptr[1]];
`endif

   assign out1_count = count[0];
   assign out2_count = count[1];

endmodule

// File: tb/tb_demux_buf.sv
// Directed, table-driven bench for demux_buf in its default (unbuffered-bypass-off) build.
module tb_demux_buf;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic             in_sel;
   logic [WIDTH-1:0] in_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out2_valid;
   logic             out2_ready;
   logic [WIDTH-1:0] out2_data;
   logic [CW-1:0]    out1_count;
   logic [CW-1:0]    out2_count;

   // Inputs for one cycle plus the outputs expected in that cycle, before its edge.
   typedef struct {
      logic          iv;
      logic          sel;
      logic [31:0]   d;
      logic          r1;
      logic          r2;
      logic          e_rdy;
      logic [CW-1:0] e_c1;
      logic [31:0]   e_d1;
      logic [CW-1:0] e_c2;
      logic [31:0]   e_d2;
   } vec_t;

   localparam int NVEC = 27;
   vec_t vecs [NVEC];

   int vectorsApplied = 0;
   int miscompares    = 0;

   always #5 clk = ~clk;

   demux_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_data    (in_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .out2_valid (out2_valid),
      .out2_ready (out2_ready),
      .out2_data  (out2_data),
      .out1_count (out1_count),
      .out2_count (out2_count)
   );

   function automatic vec_t mk(input logic iv, input logic sel, input logic [31:0] d,
                               input logic r1, input logic r2, input logic rdy,
                               input logic [CW-1:0] c1, input logic [31:0] d1,
                               input logic [CW-1:0] c2, input logic [31:0] d2);
      vec_t v;
      v.iv = iv; v.sel = sel; v.d = d; v.r1 = r1; v.r2 = r2;
      v.e_rdy = rdy; v.e_c1 = c1; v.e_d1 = d1; v.e_c2 = c2; v.e_d2 = d2;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      in_valid   = v.iv;
      in_sel     = v.sel;
      in_data    = v.d;
      out1_ready = v.r1;
      out2_ready = v.r2;
   endtask

   // Data is only meaningful while the output is valid, unless forced (reset checks).
   task automatic checkOutput(input vec_t v, input bit forceData, input string name);
      logic ev1, ev2, bad;
      ev1 = (v.e_c1 != '0);
      ev2 = (v.e_c2 != '0);
      bad = (in_ready !== v.e_rdy) || (out1_valid !== ev1) || (out2_valid !== ev2) ||
            (out1_count !== v.e_c1) || (out2_count !== v.e_c2) ||
            ((forceData || ev1) && (out1_data !== v.e_d1)) ||
            ((forceData || ev2) && (out2_data !== v.e_d2));
      vectorsApplied++;
      if (bad) begin
         miscompares++;
         $display("[TB] FAIL %s: got rdy=%b v1=%b c1=%0d d1=%h v2=%b c2=%0d d2=%h, expected rdy=%b v1=%b c1=%0d d1=%h v2=%b c2=%0d d2=%h",
                  name, in_ready, out1_valid, out1_count, out1_data, out2_valid, out2_count, out2_data,
                  v.e_rdy, ev1, v.e_c1, v.e_d1, ev2, v.e_c2, v.e_d2);
      end
   endtask

   initial begin
      //                 iv    sel   data          r1    r2    rdy   c1    d1            c2    d2
      // steering
      vecs[0]  = mk(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 2'd0, 32'h0,        2'd0, 32'h0);
      vecs[1]  = mk(1'b1, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b1, 2'd1, 32'hA5A5A5A5, 2'd0, 32'h0);
      vecs[2]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd0, 32'h0,        2'd1, 32'h5A5A5A5A);
      // fill and stall out1
      vecs[3]  = mk(1'b1, 1'b0, 32'h10000001, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        2'd0, 32'h0);
      vecs[4]  = mk(1'b1, 1'b0, 32'h10000002, 1'b0, 1'b1, 1'b1, 2'd1, 32'h10000001, 2'd0, 32'h0);
      vecs[5]  = mk(1'b1, 1'b0, 32'h10000003, 1'b0, 1'b1, 1'b0, 2'd2, 32'h10000001, 2'd0, 32'h0);
      vecs[6]  = mk(1'b1, 1'b0, 32'h10000003, 1'b0, 1'b1, 1'b0, 2'd2, 32'h10000001, 2'd0, 32'h0);
      // recovery: pop while full, ready returns next cycle
      vecs[7]  = mk(1'b1, 1'b0, 32'h10000003, 1'b1, 1'b1, 1'b0, 2'd2, 32'h10000001, 2'd0, 32'h0);
      vecs[8]  = mk(1'b1, 1'b0, 32'h10000003, 1'b0, 1'b1, 1'b1, 2'd1, 32'h10000002, 2'd0, 32'h0);
      // isolation: out1 full, out2 streaming
      vecs[9]  = mk(1'b1, 1'b1, 32'h20000001, 1'b0, 1'b1, 1'b1, 2'd2, 32'h10000002, 2'd0, 32'h0);
      vecs[10] = mk(1'b1, 1'b1, 32'h20000002, 1'b0, 1'b1, 1'b1, 2'd2, 32'h10000002, 2'd1, 32'h20000001);
      vecs[11] = mk(1'b1, 1'b1, 32'h20000003, 1'b0, 1'b1, 1'b1, 2'd2, 32'h10000002, 2'd1, 32'h20000002);
      vecs[12] = mk(1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 1'b1, 2'd2, 32'h10000002, 2'd1, 32'h20000003);
      vecs[13] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd1, 32'h10000003, 2'd0, 32'h0);
      // wrap through out2 with stalls
      vecs[14] = mk(1'b1, 1'b1, 32'h1,        1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        2'd0, 32'h0);
      vecs[15] = mk(1'b1, 1'b1, 32'h2,        1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        2'd1, 32'h1);
      vecs[16] = mk(1'b1, 1'b1, 32'h3,        1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        2'd2, 32'h1);
      vecs[17] = mk(1'b1, 1'b1, 32'h3,        1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        2'd2, 32'h1);
      vecs[18] = mk(1'b1, 1'b1, 32'h3,        1'b1, 1'b1, 1'b1, 2'd0, 32'h0,        2'd1, 32'h2);
      vecs[19] = mk(1'b1, 1'b1, 32'h4,        1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        2'd1, 32'h3);
      vecs[20] = mk(1'b1, 1'b1, 32'h5,        1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        2'd2, 32'h3);
      vecs[21] = mk(1'b1, 1'b1, 32'h5,        1'b1, 1'b1, 1'b1, 2'd0, 32'h0,        2'd1, 32'h4);
      vecs[22] = mk(1'b1, 1'b1, 32'h6,        1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        2'd1, 32'h5);
      vecs[23] = mk(1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        2'd2, 32'h5);
      vecs[24] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd0, 32'h0,        2'd1, 32'h6);
      // select ignored while in_valid is low
      vecs[25] = mk(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 2'd0, 32'h0,        2'd0, 32'h0);
      vecs[26] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd0, 32'h0,        2'd0, 32'h0);

      rst_n = 1'b0;
      applyStimulus(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 32'h0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 32'h0), 1'b1, "reset_state");
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 2'd0, 32'h0), 1'b1, "reset_release");

      for (int i = 0; i < NVEC; i++) begin
         @(posedge clk);
         #1;
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput(vecs[i], 1'b0, $sformatf("vec%0d", i));
      end

      // Reset mid-stream: word to out1 stored, then reset lands with a push to out2.
      @(posedge clk);
      #1;
      applyStimulus(mk(1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 32'h0));
      @(posedge clk);
      #1;
      applyStimulus(mk(1'b1, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 32'h0));
      @(negedge clk);
      checkOutput(mk(1'b1, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 2'd1, 32'h11111111, 2'd0, 32'h0), 1'b0, "pre_reset_push");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput(mk(1'b1, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 32'h0), 1'b1, "mid_reset");
      @(negedge clk);
      checkOutput(mk(1'b1, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 32'h0), 1'b1, "mid_reset_edge");
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput(mk(1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 2'd0, 32'h0), 1'b1, "after_mid_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
